// File: rtl/btb_update_queue.sv
// Buffers resolved-branch outcomes as BTB updates (next 2-bit counter state) and
// drains them through the BTB's single write port one entry per granted cycle.
module btb_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [29:0]                in_pc,
    input  logic [29:0]                in_target,
    input  logic                       in_taken,
    input  logic                       in_hit,
    input  logic [1:0]                 in_state,
    input  logic                       wr_grant,
    output logic                       we,
    output logic [29:0]                write_addr,
    output logic [29:0]                write_pc,
    output logic [1:0]                 write_state,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [29:0]   pc_q  [DEPTH];
    logic [29:0]   tgt_q [DEPTH];
    logic [1:0]    st_q  [DEPTH];
    logic [PW-1:0] head, tail, yng;
    logic          accept, enq, merge, push, pop;
    logic [1:0]    new_state, base_state;
    logic          dir;

    function automatic logic [1:0] sat(input logic [1:0] s, input logic up);
        if (up) return (s == 2'b11) ? 2'b11 : s + 2'b01;
        else    return (s == 2'b00) ? 2'b00 : s - 2'b01;
    endfunction

    // Input handshake: an outcome transfers when in_valid && in_ready at the
    // posedge; in_ready depends only on occupancy, never on in_valid.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

    assign we          = !empty && wr_grant;
    assign write_addr  = pc_q[head];
    assign write_pc    = tgt_q[head];
    assign write_state = st_q[head];

    assign yng    = tail - PW'(1);
    assign accept = in_valid && in_ready && !clear;
    assign enq    = accept && (in_hit || in_taken);
    // The youngest entry absorbs a repeat of the same pc unless it is leaving now.
    assign merge  = enq && !empty && (pc_q[yng] == in_pc) && !((count == CW'(1)) && we);
    assign push   = enq && !merge;
    assign pop    = we;

    always_comb begin
        base_state = in_state;
        dir        = in_taken;
        new_state  = 2'b10;
        if (merge) begin
            // in_state was read at fetch and is stale once an update is queued.
            base_state = st_q[yng];
            dir        = in_hit ? in_taken : 1'b1;
            new_state  = sat(base_state, dir);
        end else if (in_hit) begin
            new_state  = sat(base_state, dir);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
                st_q[i]  <= '0;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (merge) begin
                tgt_q[yng] <= in_target;
                st_q[yng]  <= new_state;
            end
            if (push) begin
                pc_q[tail]  <= in_pc;
                tgt_q[tail] <= in_target;
                st_q[tail]  <= new_state;
                tail        <= tail + PW'(1);
            end
            if (pop)
                head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
